hazard_scoreboard: RTL

- Consumer side of the per-stage decode tags (T_new, write register) that the stage controllers emit.
- Holds a registered scoreboard of the in-flight destination tags for the E, M and W stages, and ages their T_new each cycle.
- Compares the scoreboard against the D-stage source registers and their T_use to produce a stall/bubble request plus forwarding selects for D (branch/jr compare) and E (ALU operands).
- Sits beside the pipeline registers; the top level wires stall to the D freeze, PC freeze and E-register flush.

---
 rtl/pipe_defs.sv | 27 ++
 rtl/hazard_match.sv | 22 ++
 rtl/hazard_scoreboard.sv | 111 +++++++++++
 3 files changed

// File: rtl/pipe_defs.sv
// Shared pipeline hazard encodings: T_new / T_use codes and forward-select values.
package pipe_defs;

  localparam int unsigned REG_W_DEF = 5;
  localparam int unsigned T_W_DEF   = 2;

  // T_new of a producer on entry to E, T_use of a consumer while in D
  localparam logic [1:0] TNEW_JAL  = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LW   = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // D-stage operand source (branch/jr compare)
  typedef enum logic [1:0] {
    FWD_GRF = 2'b00,
    FWD_E   = 2'b01,
    FWD_M   = 2'b10
  } d_fwd_e;

  // E-stage operand source (ALU inputs)
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MW  = 2'b01,
    FWD_WW  = 2'b10
  } e_fwd_e;

endpackage

// File: rtl/hazard_match.sv
// Compares one consumer source (index + T_use) against one producer stage tag.
// o_hit[1] = value ready for forwarding, o_hit[0] = consumer must stall.
module hazard_match #(
  parameter int unsigned     REG_W     = 5,
  parameter int unsigned     T_W       = 2,
  parameter logic [T_W-1:0]  TUSE_NONE = '1
) (
  input  logic [REG_W-1:0] i_src,
  input  logic [T_W-1:0]   i_tuse,
  input  logic [REG_W-1:0] i_wreg,
  input  logic [T_W-1:0]   i_tnew,
  output logic [1:0]       o_hit
);

  logic w_match;

  // $0 is never a real dependency on either side
  assign w_match  = (i_src != '0) && (i_src == i_wreg);
  assign o_hit[1] = w_match && (i_tnew == '0);
  assign o_hit[0] = w_match && (i_tuse != TUSE_NONE) && (i_tnew > i_tuse);

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard of in-flight E/M/W destination tags; produces stall and the
// D/E forwarding selects for the instruction currently in D.
module hazard_scoreboard
  import pipe_defs::*;
#(
  parameter int unsigned    REG_W     = REG_W_DEF,
  parameter int unsigned    T_W       = T_W_DEF,
  parameter logic [T_W-1:0] TUSE_NONE = pipe_defs::TUSE_NONE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] D_rs,
  input  logic [REG_W-1:0] D_rt,
  input  logic [T_W-1:0]   D_Tuse_rs,
  input  logic [T_W-1:0]   D_Tuse_rt,
  input  logic [REG_W-1:0] D_Wreg,
  input  logic [T_W-1:0]   D_T_new,
  output logic             stall,
  output logic [1:0]       D_fwd_rs,
  output logic [1:0]       D_fwd_rt,
  output logic [1:0]       E_fwd_rs,
  output logic [1:0]       E_fwd_rt,
  output logic [REG_W-1:0] E_Wreg_q,
  output logic [T_W-1:0]   E_Tnew_q
);

  logic [REG_W-1:0] r_e_rs;
  logic [REG_W-1:0] r_e_rt;
  logic [REG_W-1:0] r_e_wreg;
  logic [T_W-1:0]   r_e_tnew;
  logic [REG_W-1:0] r_m_wreg;
  logic [T_W-1:0]   r_m_tnew;
  logic [REG_W-1:0] r_w_wreg;

  logic [1:0] w_hit_rs_e;
  logic [1:0] w_hit_rs_m;
  logic [1:0] w_hit_rt_e;
  logic [1:0] w_hit_rt_m;
  logic       w_stall;

  hazard_match #(.REG_W(REG_W), .T_W(T_W), .TUSE_NONE(TUSE_NONE)) u_rs_e (
    .i_src(D_rs), .i_tuse(D_Tuse_rs), .i_wreg(r_e_wreg), .i_tnew(r_e_tnew), .o_hit(w_hit_rs_e)
  );
  hazard_match #(.REG_W(REG_W), .T_W(T_W), .TUSE_NONE(TUSE_NONE)) u_rs_m (
    .i_src(D_rs), .i_tuse(D_Tuse_rs), .i_wreg(r_m_wreg), .i_tnew(r_m_tnew), .o_hit(w_hit_rs_m)
  );
  hazard_match #(.REG_W(REG_W), .T_W(T_W), .TUSE_NONE(TUSE_NONE)) u_rt_e (
    .i_src(D_rt), .i_tuse(D_Tuse_rt), .i_wreg(r_e_wreg), .i_tnew(r_e_tnew), .o_hit(w_hit_rt_e)
  );
  hazard_match #(.REG_W(REG_W), .T_W(T_W), .TUSE_NONE(TUSE_NONE)) u_rt_m (
    .i_src(D_rt), .i_tuse(D_Tuse_rt), .i_wreg(r_m_wreg), .i_tnew(r_m_tnew), .o_hit(w_hit_rt_m)
  );

  assign w_stall  = w_hit_rs_e[0] | w_hit_rs_m[0] | w_hit_rt_e[0] | w_hit_rt_m[0];
  assign stall    = w_stall;
  assign E_Wreg_q = r_e_wreg;
  assign E_Tnew_q = r_e_tnew;

  // Advance tags E->M->W every cycle; a stall loads a bubble into E
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_e_rs   <= '0;
      r_e_rt   <= '0;
      r_e_wreg <= '0;
      r_e_tnew <= '0;
      r_m_wreg <= '0;
      r_m_tnew <= '0;
      r_w_wreg <= '0;
    end else begin
      r_m_wreg <= r_e_wreg;
      r_m_tnew <= (r_e_tnew == '0) ? '0 : r_e_tnew - T_W'(1);
      r_w_wreg <= r_m_wreg;
      if (w_stall) begin
        r_e_rs   <= '0;
        r_e_rt   <= '0;
        r_e_wreg <= '0;
        r_e_tnew <= '0;
      end else begin
        r_e_rs   <= D_rs;
        r_e_rt   <= D_rt;
        r_e_wreg <= D_Wreg;
        r_e_tnew <= D_T_new;
      end
    end
  end

  // D-stage selects: only a producer whose result already exists can forward
  always_comb begin
    D_fwd_rs = FWD_GRF;
    D_fwd_rt = FWD_GRF;
    if (w_hit_rs_e[1])      D_fwd_rs = FWD_E;
    else if (w_hit_rs_m[1]) D_fwd_rs = FWD_M;
    if (w_hit_rt_e[1])      D_fwd_rt = FWD_E;
    else if (w_hit_rt_m[1]) D_fwd_rt = FWD_M;
  end

  // E-stage selects: younger stage (M) takes priority over W
  always_comb begin
    E_fwd_rs = FWD_REG;
    E_fwd_rt = FWD_REG;
    if (r_e_rs != '0) begin
      if (r_e_rs == r_m_wreg)      E_fwd_rs = FWD_MW;
      else if (r_e_rs == r_w_wreg) E_fwd_rs = FWD_WW;
    end
    if (r_e_rt != '0) begin
      if (r_e_rt == r_m_wreg)      E_fwd_rt = FWD_MW;
      else if (r_e_rt == r_w_wreg) E_fwd_rt = FWD_WW;
    end
  end

endmodule
